adsr_pulse_envelope: RTL and testbench
======================================

Name: adsr_pulse_envelope

Overview:
Second-generation ADSR pulse filter for the heartbeat video path. It generates a beat-triggered attack/decay/sustain/release brightness envelope and applies it to a circular, radially-fading pulse centred in the frame. It processes N_PIX parallel pixels per clock and sits between the pixel source and the VGA output stage. Unlike the first-generation filter, the envelope actually modulates pixel output, retriggers on each beat, uses a registered ready/valid output stage, and takes timing, sustain level and centre as parameters.

Parameters:
BITS, 8, pixel width
N_PIX, 8, parallel pixels per clock
IMAGE_WIDTH, 640, frame width
IMAGE_HEIGHT, 480, frame height
CX, IMAGE_WIDTH/2, pulse centre x
CY, IMAGE_HEIGHT/2, pulse centre y
TICK_DIV, 200000, clk cycles per envelope tick (4 ms at 50 MHz); must be >= 1
ATTACK_TICKS, 64, ticks from 0 to 255; must be >= 1
DECAY_TICKS, 64, ticks from 255 to SUSTAIN_LEVEL; must be >= 1
SUSTAIN_TICKS, 64, ticks held at SUSTAIN_LEVEL; must be >= 1
RELEASE_TICKS, 64, ticks from SUSTAIN_LEVEL to 0; must be >= 1
SUSTAIN_LEVEL, 192, sustain envelope value (0..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pix_in  in  BITS x N_PIX  input pixels
pixel_x  in  clog2(IMAGE_WIDTH) x N_PIX  x coordinate of each input pixel
pixel_y  in  clog2(IMAGE_HEIGHT)  row of the beat
valid_in  in  1  input beat valid
ready_out  out  1  block can accept a beat
pix_out  out  BITS x N_PIX  filtered pixels (registered)
valid_out  out  1  output beat valid
ready_in  in  1  downstream accepts a beat
filter_enable  in  1  0 = bypass and envelope held in IDLE
beat_trigger  in  1  single-cycle pulse at each detected heartbeat
pulse_amplitude  in  BITS  pulse radius in pixels
env_gain  out  8  current envelope value (debug)
adsr_state  out  3  current state encoding (debug)

Behaviour:
- Reset is asynchronous. All outputs are 0 after reset: pix_out, valid_out, env_gain, and adsr_state=IDLE. The tick counter and the phase counter cnt are also 0.
- Handshake: ready_out = !valid_out | ready_in.
  - An input is accepted when valid_in & ready_out. The output register loads on the next clk edge and valid_out goes to 1. Latency is 1 cycle.
  - When valid_out=1 and ready_in=0, pix_out and valid_out hold stable.
  - valid_out clears when the output is consumed and there is no new accept.
  - Full throughput: 1 beat per clock.
- Tick counter:
  - Counts 0..TICK_DIV-1 only while filter_enable=1.
  - Asserts a 1-cycle tick at TICK_DIV-1, then wraps to 0.
  - Is held at 0 while filter_enable=0.
- State encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- In all updates below, n = cnt+1.
- Envelope transitions on a tick:
  - ATTACK: env = n*255/ATTACK_TICKS. When n==ATTACK_TICKS, go to DECAY with cnt=0; otherwise cnt=n.
  - DECAY: env = 255 - n*(255-SUSTAIN_LEVEL)/DECAY_TICKS. When n==DECAY_TICKS, go to SUSTAIN.
  - SUSTAIN: env = SUSTAIN_LEVEL. When n==SUSTAIN_TICKS, go to RELEASE.
  - RELEASE: env = SUSTAIN_LEVEL - n*SUSTAIN_LEVEL/RELEASE_TICKS. When n==RELEASE_TICKS, go to IDLE with env=0.
  - IDLE: stays IDLE, env=0.
- Retrigger:
  - beat_trigger=1 with filter_enable=1 sets state to ATTACK, cnt=0, env=0 on the next edge. This applies from any state.
  - Retrigger takes priority over a tick occurring in the same cycle.
- filter_enable=0 forces state to IDLE, cnt=0, env=0 on the next edge. beat_trigger is ignored.
- Spatial gain per lane i:
  - dx = pixel_x[i]-CX and dy = pixel_y-CY, both signed at 16 bits.
  - d2 = dx*dx + dy*dy (32-bit).
  - r2 = pulse_amplitude^2 (32-bit).
  - If r2==0 or d2>=r2, spatial = 0. Otherwise spatial = ((r2-d2)*(2^BITS-1))/r2.
- Lane gain: gain = (spatial*env_gain)>>8.
- Default output: pix_out[i] = min(pix_in[i]+gain, 2^BITS-1), using a saturating add.
- Bypass: when filter_enable=0, pix_out[i] = pix_in[i]. The output is still registered and handshaked.
- The envelope value used is the env_gain register value in the accept cycle.

Optional Feature:
ADSR_BLEND_AVG_EN
- Defined: pix_out[i] = (pix_in[i]+gain)>>1, computed at BITS+1 bits. This is the legacy averaging blend, which darkens pixels outside the pulse.
- Undefined: the saturating add described above is used.
- All other behaviour is identical.

Test Plan:
1. Envelope ramp. Set TICK_DIV=4, all phase TICKS=4, SUSTAIN_LEVEL=128, and pulse beat_trigger once with filter_enable=1. Required env_gain at each tick: 63,127,191,255, then 223,191,159,128, then 128 x4, then 96,64,32,0. State must return to IDLE.
2. Centre pixel. Set pixel_x=CX, pixel_y=CY, pulse_amplitude=100, env=255, pix_in=50. Required pix_out=255 (gain 254, saturated). With ADSR_BLEND_AVG_EN defined, required pix_out=152.
3. Outside pixel. Set pixel_x=0, pixel_y=0, pulse_amplitude=100, pix_in=77. Required pix_out=77. Repeat with pulse_amplitude=0 at the centre and pix_in=77; required pix_out=77.
4. Backpressure. Hold ready_in=0 for 5 cycles after valid_out rises. Required: pix_out is stable, valid_out=1, ready_out=0. On release, there is exactly one transfer per accepted beat with no loss or duplication.
5. Retrigger collision. In SUSTAIN, assert beat_trigger in the same cycle as a tick. Required next cycle: state=ATTACK, env_gain=0. Then deassert filter_enable. Required next cycle: state=IDLE and pix_out equals pix_in.
6. Async reset. Assert reset mid-RELEASE between clock edges. Required immediately: valid_out=0, env_gain=0, adsr_state=0, pix_out=0, ready_out=1.

Source files
------------

// File: rtl/adsr_pulse_envelope_if.sv
// adsr_pulse_envelope_if: pixel beat bus with valid/ready handshake.
// Master drives pixels and ready_in, slave returns the registered beat.
interface adsr_pulse_envelope_if #(
  parameter int BITS  = 8,
  parameter int N_PIX = 8,
  parameter int XW    = 10,
  parameter int YW    = 9
);
  logic [N_PIX-1:0][BITS-1:0] pix_in;
  logic [N_PIX-1:0][XW-1:0]   pixel_x;
  logic [YW-1:0]              pixel_y;
  logic                       valid_in;
  logic                       ready_out;
  logic [N_PIX-1:0][BITS-1:0] pix_out;
  logic                       valid_out;
  logic                       ready_in;

  modport master (
    output pix_in, pixel_x, pixel_y, valid_in, ready_in,
    input  ready_out, pix_out, valid_out
  );

  modport slave (
    input  pix_in, pixel_x, pixel_y, valid_in, ready_in,
    output ready_out, pix_out, valid_out
  );
endinterface

// File: rtl/adsr_pulse_envelope.sv
// adsr_pulse_envelope: beat-retriggered ADSR envelope on a radial pulse.
// Build option ADSR_BLEND_AVG_EN selects the legacy averaging blend.
module adsr_pulse_envelope #(
  parameter int BITS          = 8,
  parameter int N_PIX         = 8,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  parameter int CX            = IMAGE_WIDTH / 2,
  parameter int CY            = IMAGE_HEIGHT / 2,
  parameter int TICK_DIV      = 200000,
  parameter int ATTACK_TICKS  = 64,
  parameter int DECAY_TICKS   = 64,
  parameter int SUSTAIN_TICKS = 64,
  parameter int RELEASE_TICKS = 64,
  parameter int SUSTAIN_LEVEL = 192
) (
  input  logic                clk,
  input  logic                reset,
  adsr_pulse_envelope_if.slave px,
  input  logic                filter_enable,
  input  logic                beat_trigger,
  input  logic [BITS-1:0]     pulse_amplitude,
  output logic [7:0]          env_gain,
  output logic [2:0]          adsr_state
);

  localparam int XW   = $clog2(IMAGE_WIDTH);
  localparam int YW   = $clog2(IMAGE_HEIGHT);
  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW   = BITS + 8;
  localparam int PMAX = (1 << BITS) - 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [15:0]                cnt_q, cnt_d;
  logic [7:0]                 env_q, env_d;
  logic [TW-1:0]              tick_q, tick_d;
  logic                       tick;
  logic                       valid_q, valid_d;
  logic [N_PIX-1:0][BITS-1:0] pix_q, pix_d;
  logic                       ready;
  logic                       accept;
  int                         n;

  // Per-lane pulse gain blended into one pixel.
  function automatic logic [BITS-1:0] lane_out(
    input logic [BITS-1:0] pix,
    input logic [XW-1:0]   x,
    input logic [YW-1:0]   y,
    input logic [BITS-1:0] amp,
    input logic [7:0]      env
  );
    logic signed [15:0] dx, dy;
    logic signed [31:0] dxw, dyw;
    logic [31:0]        d2, r2;
    logic [63:0]        prod;
    logic [BITS-1:0]    spatial;
    logic [GW-1:0]      g;
    logic [BITS-1:0]    gain;
    logic [BITS:0]      sum;
    dx  = 16'(x) - 16'(CX);
    dy  = 16'(y) - 16'(CY);
    dxw = 32'(dx);
    dyw = 32'(dy);
    d2  = dxw * dxw + dyw * dyw;
    r2  = 32'(amp) * 32'(amp);
    if (r2 == 32'd0 || d2 >= r2) begin
      spatial = '0;
    end else begin
      prod    = 64'(r2 - d2) * 64'(PMAX);
      spatial = BITS'(prod / 64'(r2));
    end
    g    = GW'(spatial) * GW'(env);
    gain = BITS'(g >> 8);
    sum  = {1'b0, pix} + {1'b0, gain};
`ifdef ADSR_BLEND_AVG_EN
    return BITS'(sum >> 1);
`else
    return sum[BITS] ? BITS'(PMAX) : BITS'(sum);
`endif
  endfunction

  // State register: envelope, phase counter, tick divider, output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      env_q   <= '0;
      tick_q  <= '0;
      valid_q <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      env_q   <= env_d;
      tick_q  <= tick_d;
      valid_q <= valid_d;
      pix_q   <= pix_d;
    end
  end

  // Tick divider runs only while the filter is enabled.
  always_comb begin
    tick   = filter_enable && (tick_q == TW'(TICK_DIV - 1));
    tick_d = '0;
    if (filter_enable && !tick)
      tick_d = tick_q + 1'b1;
  end

  // Next state: disable, then retrigger, then tick-driven ramp.
  // Ramps truncate the exact interpolated value, not the per-step size.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    env_d   = env_q;
    n       = int'(cnt_q) + 1;
    if (!filter_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      env_d   = '0;
    end else if (beat_trigger) begin
      state_d = ATTACK;
      cnt_d   = '0;
      env_d   = '0;
    end else if (tick) begin
      unique case (state_q)
        ATTACK: begin
          env_d = 8'((n * 255) / ATTACK_TICKS);
          cnt_d = 16'(n);
          if (n == ATTACK_TICKS) begin
            state_d = DECAY;
            cnt_d   = '0;
          end
        end
        DECAY: begin
          env_d = 8'((255 * DECAY_TICKS
                  - n * (255 - SUSTAIN_LEVEL)) / DECAY_TICKS);
          cnt_d = 16'(n);
          if (n == DECAY_TICKS) begin
            state_d = SUSTAIN;
            cnt_d   = '0;
          end
        end
        SUSTAIN: begin
          env_d = 8'(SUSTAIN_LEVEL);
          cnt_d = 16'(n);
          if (n == SUSTAIN_TICKS) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end
        RELEASE: begin
          env_d = 8'((SUSTAIN_LEVEL * RELEASE_TICKS
                  - n * SUSTAIN_LEVEL) / RELEASE_TICKS);
          cnt_d = 16'(n);
          if (n == RELEASE_TICKS) begin
            state_d = IDLE;
            cnt_d   = '0;
            env_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          env_d   = '0;
        end
      endcase
    end
  end

  // Debug outputs mirror the envelope registers.
  always_comb begin
    adsr_state = state_q;
    env_gain   = env_q;
  end

  // Output stage: load on accept, hold under backpressure.
  always_comb begin
    ready   = !valid_q || px.ready_in;
    accept  = px.valid_in && ready;
    valid_d = valid_q;
    pix_d   = pix_q;
    if (accept) begin
      valid_d = 1'b1;
      for (int i = 0; i < N_PIX; i++) begin
        pix_d[i] = filter_enable
          ? lane_out(px.pix_in[i], px.pixel_x[i], px.pixel_y,
                     pulse_amplitude, env_q)
          : px.pix_in[i];
      end
    end else if (px.ready_in) begin
      valid_d = 1'b0;
    end
  end

  assign px.ready_out = ready;
  assign px.pix_out   = pix_q;
  assign px.valid_out = valid_q;

endmodule

// File: tb/tb_adsr_pulse_envelope.sv
// tb_adsr_pulse_envelope: random and directed checks against a
// tick-count envelope model and an arithmetic pixel model.
module tb_adsr_pulse_envelope;
  localparam int BITS  = 8;
  localparam int N_PIX = 8;
  localparam int W     = 640;
  localparam int H     = 480;
  localparam int CX    = W / 2;
  localparam int CY    = H / 2;
  localparam int XW    = $clog2(W);
  localparam int YW    = $clog2(H);
  localparam int TD    = 4;
  localparam int A     = 4;
  localparam int D     = 4;
  localparam int S     = 4;
  localparam int R     = 4;
  localparam int SL    = 128;
  localparam int KMAX  = A + D + S + R;

  logic            clk = 1'b0;
  logic            reset;
  logic            filter_enable;
  logic            beat_trigger;
  logic [BITS-1:0] pulse_amplitude;
  logic [7:0]      env_gain;
  logic [2:0]      adsr_state;

  adsr_pulse_envelope_if #(
    .BITS(BITS), .N_PIX(N_PIX), .XW(XW), .YW(YW)
  ) bus ();

  adsr_pulse_envelope #(
    .BITS(BITS), .N_PIX(N_PIX),
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CX(CX), .CY(CY),
    .TICK_DIV(TD), .ATTACK_TICKS(A), .DECAY_TICKS(D),
    .SUSTAIN_TICKS(S), .RELEASE_TICKS(R), .SUSTAIN_LEVEL(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .px(bus),
    .filter_enable(filter_enable),
    .beat_trigger(beat_trigger),
    .pulse_amplitude(pulse_amplitude),
    .env_gain(env_gain),
    .adsr_state(adsr_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state: ticks since last trigger, divider phase, output reg
  bit          m_active;
  int          m_k;
  int          m_phase;
  bit          m_valid;
  logic [63:0] m_pix;
  int          acc;
  int          xfer;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int env_at(int k);
    real v;
    if (k <= A)
      v = 255.0 * k / A;
    else if (k <= A + D)
      v = 255.0 - real'(k - A) * (255 - SL) / D;
    else if (k <= A + D + S)
      v = SL;
    else if (k <= KMAX)
      v = SL - real'(k - A - D - S) * SL / R;
    else
      v = 0.0;
    return int'($floor(v));
  endfunction

  function automatic int state_at(int k);
    if (k < A)         return 1;
    if (k < A + D)     return 2;
    if (k < A + D + S) return 3;
    if (k < KMAX)      return 4;
    return 0;
  endfunction

  function automatic int cur_env();
    return m_active ? env_at(m_k) : 0;
  endfunction

  function automatic int cur_state();
    return m_active ? state_at(m_k) : 0;
  endfunction

  function automatic int exp_lane(int pix, int x, int y, int amp,
                                  int env, bit en);
    longint dx, dy, d2, r2, sp, g, s;
    if (!en) return pix;
    dx = x - CX;
    dy = y - CY;
    d2 = dx * dx + dy * dy;
    r2 = amp * amp;
    sp = (r2 == 0 || d2 >= r2) ? 0 : ((r2 - d2) * 255) / r2;
    g  = (sp * env) / 256;
    s  = pix + g;
`ifdef ADSR_BLEND_AVG_EN
    return int'(s / 2);
`else
    return (s > 255) ? 255 : int'(s);
`endif
  endfunction

  function automatic void model_reset();
    m_active = 0;
    m_k      = 0;
    m_phase  = 0;
    m_valid  = 0;
    m_pix    = '0;
  endfunction

  // one clock: predict, advance, compare
  task automatic cycle();
    int          env_now = cur_env();
    bit          rdy     = !m_valid || bus.ready_in;
    bit          n_valid = m_valid;
    logic [63:0] n_pix   = m_pix;
    bit          tk      = filter_enable && (m_phase == TD - 1);
    #1;
    check("ready_out", bus.ready_out, rdy);
    if (bus.valid_in && rdy) begin
      n_valid = 1;
      acc++;
      for (int i = 0; i < N_PIX; i++)
        n_pix[i*BITS +: BITS] = BITS'(exp_lane(
          int'(bus.pix_in[i]), int'(bus.pixel_x[i]), int'(bus.pixel_y),
          int'(pulse_amplitude), env_now, filter_enable));
    end else if (bus.ready_in) begin
      n_valid = 0;
    end
    if (m_valid && bus.ready_in) xfer++;
    @(posedge clk);
    #1;
    m_valid = n_valid;
    m_pix   = n_pix;
    m_phase = filter_enable ? (m_phase + 1) % TD : 0;
    if (!filter_enable) begin
      m_active = 0;
      m_k      = 0;
    end else if (beat_trigger) begin
      m_active = 1;
      m_k      = 0;
    end else if (tk && m_active && m_k < KMAX) begin
      m_k++;
    end
    check("valid_out", bus.valid_out, m_valid);
    check("pix_out", bus.pix_out, m_pix);
    check("env_gain", env_gain, cur_env());
    check("adsr_state", adsr_state, cur_state());
  endtask

  task automatic drive_rand();
    bus.valid_in = ($urandom_range(3) != 0);
    bus.ready_in = ($urandom_range(3) != 0);
    bus.pixel_y  = YW'(CY - 20 + int'($urandom_range(40)));
    for (int i = 0; i < N_PIX; i++) begin
      bus.pix_in[i]  = BITS'($urandom);
      bus.pixel_x[i] = ($urandom_range(1) == 1)
        ? XW'(CX - 60 + int'($urandom_range(120)))
        : XW'($urandom_range(W - 1));
    end
    case ($urandom_range(2))
      0:       pulse_amplitude = '0;
      1:       pulse_amplitude = BITS'(100);
      default: pulse_amplitude = BITS'($urandom);
    endcase
  endtask

  task automatic trigger_once();
    filter_enable = 1'b1;
    beat_trigger  = 1'b1;
    cycle();
    beat_trigger  = 1'b0;
  endtask

  logic [63:0] held;
  logic [63:0] sent;
  int          guard;

  initial begin
    model_reset();
    acc  = 0;
    xfer = 0;
    reset = 1'b1;
    filter_enable = 1'b0;
    beat_trigger  = 1'b0;
    pulse_amplitude = '0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    bus.pix_in   = '0;
    bus.pixel_x  = '0;
    bus.pixel_y  = '0;
    #12;
    check("rst_valid", bus.valid_out, 0);
    check("rst_pix", bus.pix_out, 0);
    check("rst_env", env_gain, 0);
    check("rst_state", adsr_state, 0);
    check("rst_ready", bus.ready_out, 1);
    @(posedge clk);
    #1 reset = 1'b0;

    // full envelope ramp with random traffic
    trigger_once();
    for (int c = 0; c < TD * (KMAX + 3); c++) begin
      drive_rand();
      cycle();
    end
    check("ramp_idle", adsr_state, 0);

    // random mix of enables, triggers and pixels
    for (int c = 0; c < 400; c++) begin
      drive_rand();
      filter_enable = ($urandom_range(15) != 0);
      beat_trigger  = ($urandom_range(39) == 0);
      cycle();
    end
    beat_trigger = 1'b0;

    // centre pixel at envelope peak
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    trigger_once();
    guard = 0;
    while (cur_env() != 255 && guard < 60) begin
      cycle();
      guard++;
    end
    check("env_peak", env_gain, 255);
    bus.valid_in   = 1'b1;
    bus.pixel_y    = YW'(CY);
    bus.pixel_x[0] = XW'(CX);
    bus.pix_in[0]  = BITS'(50);
    pulse_amplitude = BITS'(100);
    cycle();
`ifdef ADSR_BLEND_AVG_EN
    check("centre", bus.pix_out[0], 152);
`else
    check("centre", bus.pix_out[0], 255);
`endif
    bus.pixel_y    = '0;
    bus.pixel_x[0] = '0;
    bus.pix_in[0]  = BITS'(77);
    cycle();
`ifdef ADSR_BLEND_AVG_EN
    check("outside", bus.pix_out[0], 38);
`else
    check("outside", bus.pix_out[0], 77);
`endif
    bus.pixel_y    = YW'(CY);
    bus.pixel_x[0] = XW'(CX);
    pulse_amplitude = '0;
    cycle();
`ifdef ADSR_BLEND_AVG_EN
    check("zero_amp", bus.pix_out[0], 38);
`else
    check("zero_amp", bus.pix_out[0], 77);
`endif

    // backpressure for 5 cycles
    drive_rand();
    bus.valid_in = 1'b1;
    bus.ready_in = 1'b1;
    cycle();
    held = bus.pix_out;
    for (int c = 0; c < 5; c++) begin
      drive_rand();
      bus.ready_in = 1'b0;
      cycle();
      check("bp_hold", bus.pix_out, held);
      check("bp_ready", bus.ready_out, 0);
    end
    for (int c = 0; c < 20; c++) begin
      drive_rand();
      cycle();
    end

    // retrigger colliding with a tick in sustain
    bus.valid_in = 1'b0;
    trigger_once();
    guard = 0;
    while (!(cur_state() == 3 && m_phase == TD - 1) && guard < 100) begin
      cycle();
      guard++;
    end
    check("in_sustain", adsr_state, 3);
    beat_trigger = 1'b1;
    cycle();
    beat_trigger = 1'b0;
    check("retrig_state", adsr_state, 1);
    check("retrig_env", env_gain, 0);
    drive_rand();
    bus.valid_in  = 1'b1;
    bus.ready_in  = 1'b1;
    filter_enable = 1'b0;
    sent = bus.pix_in;
    cycle();
    check("dis_state", adsr_state, 0);
    check("bypass", bus.pix_out, sent);

    // async reset in the middle of release
    bus.valid_in = 1'b0;
    trigger_once();
    guard = 0;
    while (cur_state() != 4 && guard < 100) begin
      drive_rand();
      cycle();
      guard++;
    end
    check("in_release", adsr_state, 4);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", bus.valid_out, 0);
    check("ar_env", env_gain, 0);
    check("ar_state", adsr_state, 0);
    check("ar_pix", bus.pix_out, 0);
    check("ar_ready", bus.ready_out, 1);
    model_reset();
    acc  = 0;
    xfer = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      drive_rand();
      filter_enable = 1'b1;
      beat_trigger  = ($urandom_range(29) == 0);
      cycle();
    end
    check("xfer_count", 64'(xfer + int'(bus.valid_out)), 64'(acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
